// File: rtl/aliens_io_pkg.sv
// Shared constants for the Aliens I/O port block: register offsets inside the
// 0x5F80-0x5F9F window, control-register bit positions and the read-data mux.
package aliens_io_pkg;

  localparam logic [3:0] IO_OFS_DSW3 = 4'h0;
  localparam logic [3:0] IO_OFS_P1   = 4'h1;
  localparam logic [3:0] IO_OFS_P2   = 4'h2;
  localparam logic [3:0] IO_OFS_DSW2 = 4'h3;
  localparam logic [3:0] IO_OFS_DSW1 = 4'h4;
  localparam logic [3:0] IO_OFS_CTRL = 4'h8;
  localparam logic [3:0] IO_OFS_SND  = 4'hC;

  localparam int CTRL_COIN1 = 0;
  localparam int CTRL_COIN2 = 1;
  localparam int CTRL_RMRD  = 5;

  // Unmapped read offsets float high on the real board, hence 0xFF.
  function automatic logic [7:0] io_read_mux(
    input logic [3:0] ofs,
    input logic [7:0] p1,
    input logic [7:0] p2,
    input logic [7:0] dsw1,
    input logic [7:0] dsw2,
    input logic [3:0] dsw3
  );
    logic [7:0] data;
    data = 8'hFF;
    case (ofs)
      IO_OFS_DSW3: data = {4'hF, dsw3};
      IO_OFS_P1:   data = p1;
      IO_OFS_P2:   data = p2;
      IO_OFS_DSW2: data = dsw2;
      IO_OFS_DSW1: data = dsw1;
      default:     data = 8'hFF;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/aliens_io_watchdog.sv
// Frame-based watchdog: counts VBLANK rising edges since the last kick and
// emits a fixed-length reset pulse once WDOG_FRAMES frames pass unkicked.
module aliens_io_watchdog
  import aliens_io_pkg::*;
#(
  parameter int WDOG_FRAMES = 16,
  parameter int WDOG_PULSE  = 64
) (
  input  logic CLK12,
  input  logic RST,
  input  logic VBLANK,
  input  logic KICK,
  output logic WDOG_RST
);

  localparam int PW = (WDOG_PULSE > 1) ? $clog2(WDOG_PULSE) : 1;

  logic          vblank_q;
  logic [7:0]    frame_cnt;
  logic [PW-1:0] pulse_cnt;
  logic          pulse_q;
  logic          vblank_rise;
  logic          timeout;

  assign vblank_rise = VBLANK & ~vblank_q;
  // A kick in the same cycle as the final frame edge cancels the timeout.
  assign timeout     = vblank_rise & ~KICK & (frame_cnt == 8'(WDOG_FRAMES - 1));
  assign WDOG_RST    = pulse_q;

  always_ff @(posedge CLK12) begin
    if (RST) begin
      vblank_q  <= 1'b0;
      frame_cnt <= '0;
      pulse_cnt <= '0;
      pulse_q   <= 1'b0;
    end else begin
      vblank_q <= VBLANK;

      if (KICK || timeout) begin
        frame_cnt <= '0;
      end else if (vblank_rise) begin
        frame_cnt <= frame_cnt + 8'd1;
      end

      // The pulse runs to completion; kicks only affect the frame counter.
      if (timeout && !pulse_q) begin
        pulse_q   <= 1'b1;
        pulse_cnt <= PW'(WDOG_PULSE - 1);
      end else if (pulse_q) begin
        if (pulse_cnt == '0) begin
          pulse_q <= 1'b0;
        end else begin
          pulse_cnt <= pulse_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/aliens_io_ports.sv
// Aliens main-CPU I/O port block: input/DIP reads, control and sound-command
// latches, optional frame watchdog (built when ALIENS_IO_WATCHDOG_EN is defined).
module aliens_io_ports
  import aliens_io_pkg::*;
#(
  parameter int WDOG_FRAMES = 16,
  parameter int WDOG_PULSE  = 64
) (
  input  logic       CLK12,
  input  logic       RST,
  input  logic       IOCS,
  input  logic       AS,
  input  logic       RWb,
  input  logic [4:0] ADDR,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       DOE,
  input  logic [7:0] P1,
  input  logic [7:0] P2,
  input  logic [7:0] DSW1,
  input  logic [7:0] DSW2,
  input  logic [3:0] DSW3,
  input  logic       VBLANK,
  input  logic       SND_IACK,
  output logic [7:0] CTRL,
  output logic       COIN1,
  output logic       COIN2,
  output logic       RMRD,
  output logic [7:0] SND_LATCH,
  output logic       SND_IRQ,
  output logic       WDOG_RST
);

  // Read handshake: DOE is a registered valid with no back-pressure. It is
  // high the cycle after rd_sel, DOUT is meaningful only while DOE is high,
  // and DOUT keeps its last value once DOE drops.

  logic [3:0] ofs;
  logic       rd_sel;
  logic       wr_sel;
  logic       wr_idle_q;
  logic       wr_commit;
  logic       ctrl_wr;
  logic       snd_wr;
  logic       iack_q;
  logic       iack_rise;

  assign ofs    = ADDR[3:0];
  assign rd_sel = ~IOCS & ~AS & RWb;
  assign wr_sel = ~IOCS & ~AS & ~RWb;

  // wr_idle_q records "wr_sel was low last cycle". Clearing it in reset means
  // a strobe still held when reset releases must drop before it can commit.
  assign wr_commit = wr_sel & wr_idle_q;
  assign ctrl_wr   = wr_commit & (ofs == IO_OFS_CTRL);
  assign snd_wr    = wr_commit & (ofs == IO_OFS_SND);
  assign iack_rise = SND_IACK & ~iack_q;

  assign COIN1 = CTRL[CTRL_COIN1];
  assign COIN2 = CTRL[CTRL_COIN2];
  assign RMRD  = CTRL[CTRL_RMRD];

  always_ff @(posedge CLK12) begin
    if (RST) begin
      DOUT      <= 8'h00;
      DOE       <= 1'b0;
      CTRL      <= 8'h00;
      SND_LATCH <= 8'h00;
      SND_IRQ   <= 1'b0;
      wr_idle_q <= 1'b0;
      iack_q    <= 1'b0;
    end else begin
      DOE <= rd_sel;
      if (rd_sel) begin
        DOUT <= io_read_mux(ofs, P1, P2, DSW1, DSW2, DSW3);
      end

      wr_idle_q <= ~wr_sel;
      iack_q    <= SND_IACK;

      if (ctrl_wr) begin
        CTRL <= DIN;
      end
      if (snd_wr) begin
        SND_LATCH <= DIN;
      end

      // A new command outranks an acknowledge arriving in the same cycle.
      if (snd_wr) begin
        SND_IRQ <= 1'b1;
      end else if (iack_rise) begin
        SND_IRQ <= 1'b0;
      end
    end
  end

`ifdef ALIENS_IO_WATCHDOG_EN
  aliens_io_watchdog #(
    .WDOG_FRAMES (WDOG_FRAMES),
    .WDOG_PULSE  (WDOG_PULSE)
  ) u_watchdog (
    .CLK12    (CLK12),
    .RST      (RST),
    .VBLANK   (VBLANK),
    .KICK     (ctrl_wr),
    .WDOG_RST (WDOG_RST)
  );

  logic unused_bits;
  assign unused_bits = ADDR[4];
`else
  assign WDOG_RST = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{ADDR[4], VBLANK, WDOG_FRAMES[0], WDOG_PULSE[0]};
`endif

endmodule

// File: tb/tb_aliens_io_ports.sv
// Bench for aliens_io_ports: read data scoreboarded through a queue drained by a
// DOE monitor; write, sound-IRQ, watchdog and reset behaviour checked directly.
module tb_aliens_io_ports;

  logic       CLK12 = 1'b0;
  logic       RST;
  logic       IOCS;
  logic       AS;
  logic       RWb;
  logic [4:0] ADDR;
  logic [7:0] DIN;
  logic [7:0] DOUT;
  logic       DOE;
  logic [7:0] P1;
  logic [7:0] P2;
  logic [7:0] DSW1;
  logic [7:0] DSW2;
  logic [3:0] DSW3;
  logic       VBLANK;
  logic       SND_IACK;
  logic [7:0] CTRL;
  logic       COIN1;
  logic       COIN2;
  logic       RMRD;
  logic [7:0] SND_LATCH;
  logic       SND_IRQ;
  logic       WDOG_RST;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_rd;
  int         wd_run = 0;
  int         wd_last = 0;
  int         wd_pulses = 0;

  aliens_io_ports #(
    .WDOG_FRAMES (16),
    .WDOG_PULSE  (64)
  ) dut (
    .CLK12     (CLK12),
    .RST       (RST),
    .IOCS      (IOCS),
    .AS        (AS),
    .RWb       (RWb),
    .ADDR      (ADDR),
    .DIN       (DIN),
    .DOUT      (DOUT),
    .DOE       (DOE),
    .P1        (P1),
    .P2        (P2),
    .DSW1      (DSW1),
    .DSW2      (DSW2),
    .DSW3      (DSW3),
    .VBLANK    (VBLANK),
    .SND_IACK  (SND_IACK),
    .CTRL      (CTRL),
    .COIN1     (COIN1),
    .COIN2     (COIN2),
    .RMRD      (RMRD),
    .SND_LATCH (SND_LATCH),
    .SND_IRQ   (SND_IRQ),
    .WDOG_RST  (WDOG_RST)
  );

  // Clock and reset
  always #5 CLK12 = ~CLK12;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every DOE cycle consumes one expected read value.
  always @(negedge CLK12) begin
    if (!RST && DOE) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL read_unexpected: DOE=1 DOUT=%0h expected no read data", DOUT);
      end else begin
        exp_rd = exp_q.pop_front();
        check("read_data", {24'h0, DOUT}, {24'h0, exp_rd});
      end
    end
  end

  // Watchdog pulse length monitor.
  always @(negedge CLK12) begin
    if (WDOG_RST) begin
      wd_run++;
    end else if (wd_run != 0) begin
      wd_last = wd_run;
      wd_run = 0;
      wd_pulses++;
    end
  end

  // Driver tasks
  task automatic bus_idle();
    IOCS = 1'b1;
    AS   = 1'b1;
    RWb  = 1'b1;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [7:0] e);
    @(posedge CLK12); #1;
    IOCS = 1'b0; AS = 1'b0; RWb = 1'b1; ADDR = a;
    exp_q.push_back(e);
    @(posedge CLK12); #1;
    bus_idle();
  endtask

  // Data changes after the first edge so a second commit would be visible.
  task automatic do_write(input logic [4:0] a, input logic [7:0] d, input int hold);
    @(posedge CLK12); #1;
    IOCS = 1'b0; AS = 1'b0; RWb = 1'b0; ADDR = a; DIN = d;
    @(posedge CLK12); #1;
    DIN = ~d;
    repeat (hold - 1) @(posedge CLK12);
    #1;
    bus_idle();
  endtask

  task automatic vblank_edge();
    @(posedge CLK12); #1;
    VBLANK = 1'b1;
    @(posedge CLK12); #1;
    VBLANK = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    bus_idle();
    ADDR = 5'h00; DIN = 8'h00;
    P1 = 8'hA5; P2 = 8'h5A; DSW1 = 8'h3C; DSW2 = 8'hC3; DSW3 = 4'h3;
    VBLANK = 1'b0; SND_IACK = 1'b0;
    repeat (3) @(posedge CLK12);
    #1 RST = 1'b0;

    @(negedge CLK12);
    check("rst_dout", DOUT, 8'h00);
    check("rst_doe", DOE, 1'b0);
    check("rst_ctrl", CTRL, 8'h00);
    check("rst_coin1", COIN1, 1'b0);
    check("rst_snd_latch", SND_LATCH, 8'h00);
    check("rst_snd_irq", SND_IRQ, 1'b0);
    check("rst_wdog", WDOG_RST, 1'b0);

    // Reads, including mirrored and unmapped offsets
    do_read(5'h01, 8'hA5);
    do_read(5'h00, 8'hF3);
    do_read(5'h07, 8'hFF);
    do_read(5'h02, 8'h5A);
    do_read(5'h03, 8'hC3);
    do_read(5'h04, 8'h3C);
    do_read(5'h11, 8'hA5);
    do_read(5'h0C, 8'hFF);
    do_read(5'h18, 8'hFF);
    do_read(5'h13, 8'hC3);
    P1 = 8'h00;
    repeat (2) @(posedge CLK12);
    @(negedge CLK12);
    check("doe_idle", DOE, 1'b0);
    check("dout_hold", DOUT, 8'hC3);

    // Control register writes
    do_write(5'h08, 8'h23, 5);
    @(negedge CLK12);
    check("ctrl_once", CTRL, 8'h23);
    check("coin1_set", COIN1, 1'b1);
    check("coin2_set", COIN2, 1'b1);
    check("rmrd_set", RMRD, 1'b1);
    do_write(5'h18, 8'h04, 3);
    @(negedge CLK12);
    check("ctrl_mirror", CTRL, 8'h04);
    check("coin1_clr", COIN1, 1'b0);
    check("rmrd_clr", RMRD, 1'b0);
    do_write(5'h09, 8'hFF, 2);
    @(negedge CLK12);
    check("ignored_ctrl", CTRL, 8'h04);
    check("ignored_snd", SND_LATCH, 8'h00);

    // Sound latch and IRQ
    do_write(5'h0C, 8'h42, 2);
    @(negedge CLK12);
    check("snd_latch_1", SND_LATCH, 8'h42);
    check("snd_irq_set", SND_IRQ, 1'b1);
    do_write(5'h1C, 8'h43, 4);
    @(negedge CLK12);
    check("snd_latch_over", SND_LATCH, 8'h43);
    check("snd_irq_held", SND_IRQ, 1'b1);
    @(posedge CLK12); #1;
    SND_IACK = 1'b1;
    @(negedge CLK12);
    check("snd_irq_pre_ack", SND_IRQ, 1'b1);
    @(negedge CLK12);
    check("snd_irq_ack", SND_IRQ, 1'b0);
    @(posedge CLK12); #1;
    SND_IACK = 1'b0;
    @(posedge CLK12); #1;
    SND_IACK = 1'b1;
    IOCS = 1'b0; AS = 1'b0; RWb = 1'b0; ADDR = 5'h0C; DIN = 8'h55;
    @(posedge CLK12); #1;
    bus_idle();
    @(negedge CLK12);
    check("snd_coinc_irq", SND_IRQ, 1'b1);
    check("snd_coinc_latch", SND_LATCH, 8'h55);
    @(negedge CLK12);
    check("snd_irq_iack_level", SND_IRQ, 1'b1);
    @(posedge CLK12); #1;
    SND_IACK = 1'b0;

    // Watchdog
`ifdef ALIENS_IO_WATCHDOG_EN
    repeat (15) vblank_edge();
    do_write(5'h08, 8'h81, 2);
    repeat (15) vblank_edge();
    repeat (4) @(posedge CLK12);
    @(negedge CLK12);
    check("wdog_kicked_low", WDOG_RST, 1'b0);
    check("wdog_kicked_pulses", wd_pulses, 0);
    @(posedge CLK12); #1;
    VBLANK = 1'b1;
    @(posedge CLK12);
    @(negedge CLK12);
    check("wdog_rise", WDOG_RST, 1'b1);
    VBLANK = 1'b0;
    repeat (10) @(posedge CLK12);
    do_write(5'h08, 8'h81, 2);
    repeat (70) @(posedge CLK12);
    @(negedge CLK12);
    check("wdog_pulse_count", wd_pulses, 1);
    check("wdog_pulse_len", wd_last, 64);
    repeat (16) vblank_edge();
    @(negedge CLK12);
    check("wdog_pre_reset", WDOG_RST, 1'b1);
`else
    repeat (16) vblank_edge();
    repeat (80) @(posedge CLK12);
    @(negedge CLK12);
    check("wdog_off_low", WDOG_RST, 1'b0);
    check("wdog_off_pulses", wd_pulses, 0);
`endif
    check("irq_pre_reset", SND_IRQ, 1'b1);

    // Reset while busy, with a write strobe held across reset release
    @(posedge CLK12); #1;
    RST = 1'b1;
    IOCS = 1'b0; AS = 1'b0; RWb = 1'b0; ADDR = 5'h08; DIN = 8'h77;
    @(negedge CLK12);
    @(negedge CLK12);
    check("rst2_wdog", WDOG_RST, 1'b0);
    check("rst2_irq", SND_IRQ, 1'b0);
    check("rst2_ctrl", CTRL, 8'h00);
    check("rst2_latch", SND_LATCH, 8'h00);
    @(posedge CLK12); #1;
    RST = 1'b0;
    repeat (3) @(posedge CLK12);
    @(negedge CLK12);
    check("held_strobe_no_commit", CTRL, 8'h00);
    #1 bus_idle();
    do_write(5'h08, 8'h5A, 1);
    @(negedge CLK12);
    check("post_reset_write", CTRL, 8'h5A);

    repeat (3) @(posedge CLK12);
    check("read_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/aliens_io_ports.md
# aliens_io_ports

Memory-mapped I/O port block for the Aliens main-CPU bus, directly downstream of the bus-control decoder. It consumes the decoder's `IOCS` select in the 0x5F80–0x5F9F window. It returns player inputs and DIP switches on reads. On writes it latches the control register (coin counters, `RMRD`), the sound-command latch with a held sound IRQ, and kicks the frame-based watchdog.

## Interface
Parameters:
- `WDOG_FRAMES`, 16: VBLANK rising edges without a kick before a watchdog reset.
- `WDOG_PULSE`, 64: length of the `WDOG_RST` pulse, in `CLK12` cycles.

Ports:
- `CLK12` in 1: single system clock; all state updates on its rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `IOCS` in 1: I/O select from the bus decoder, active-low.
- `AS` in 1: CPU address strobe, active-low.
- `RWb` in 1: 1 = read, 0 = write.
- `ADDR` in 5: CPU address bits [4:0].
- `DIN` in 8: CPU write data.
- `DOUT` out 8: read data, registered.
- `DOE` out 1: `DOUT` valid / drive enable, registered.
- `P1`, `P2` in 8 each: player inputs, active-low, already synchronous to `CLK12`.
- `DSW1`, `DSW2` in 8 each; `DSW3` in 4: DIP switches.
- `VBLANK` in 1: vertical blank, synchronous to `CLK12`.
- `SND_IACK` in 1: sound-CPU interrupt acknowledge, synchronous.
- `CTRL` out 8: raw control register.
- `COIN1`, `COIN2`, `RMRD` out 1 each: `CTRL` bits 0, 1 and 5.
- `SND_LATCH` out 8: sound command.
- `SND_IRQ` out 1: sound-CPU IRQ request, active-high, level.
- `WDOG_RST` out 1: watchdog reset request, active-high.

## Operation
Decode:
- `ADDR[4]` is ignored (mirror). The offset is `ADDR[3:0]`.

Reads:
- 0: `{4'hF, DSW3}`
- 1: `P1`
- 2: `P2`
- 3: `DSW2`
- 4: `DSW1`
- All other offsets: 0xFF.

Writes:
- 8: `CTRL <= DIN`, and watchdog kick.
- C: `SND_LATCH <= DIN`, `SND_IRQ <= 1`.
- All other offsets: ignored.

Select and commit:
- `rd_sel = !IOCS & !AS & RWb`
- `wr_sel = !IOCS & !AS & !RWb`
- A write commits exactly once per bus cycle, on the first `CLK12` edge where `wr_sel` = 1 and the previous-cycle `wr_sel` = 0 (rising-edge detect). A strobe held for N cycles produces one commit.

Sound IRQ:
- `SND_IRQ` clears on a rising edge of `SND_IACK`.
- A write to C while `SND_IRQ` is already 1 overwrites `SND_LATCH`; the IRQ stays 1.
- A write to C in the same cycle as an `SND_IACK` rise: the write wins, so `SND_IRQ` stays 1.

Watchdog:
- An 8-bit frame counter increments on each `VBLANK` rising edge and clears on a kick.
- A kick and a VBLANK edge in the same cycle: the kick wins, so the counter goes to 0.
- When the counter reaches `WDOG_FRAMES`, `WDOG_RST` goes to 1 for exactly `WDOG_PULSE` cycles and the counter clears.
- Kicks during the pulse reset the frame counter but do not shorten the pulse.

## Timing
- Reset values:
  - `DOUT` = 0x00, `DOE` = 0
  - `CTRL` = 0x00, so `COIN1`/`COIN2`/`RMRD` = 0
  - `SND_LATCH` = 0x00, `SND_IRQ` = 0
  - `WDOG_RST` = 0
  - All counters and edge registers = 0
- Read latency: `DOUT`/`DOE` reflect the offset and inputs sampled one `CLK12` after `rd_sel`. `DOE` drops one cycle after `rd_sel` drops. `DOUT` holds its last value when `DOE` = 0.
- Write latency: `CTRL`, `SND_LATCH`, `SND_IRQ` and the kick take effect one cycle after the `wr_sel` rise.
- `SND_IRQ` falls one cycle after the `SND_IACK` rise.
- `WDOG_RST` rises one cycle after the timeout edge.
- `RST` during a `WDOG_RST` pulse, a pending IRQ or an active read: all outputs return to reset values on the next edge. Edge detectors are cleared, so a strobe still held after reset does not commit.

## Configuration
- `ALIENS_IO_WATCHDOG_EN` defined: watchdog logic is built as described above.
- `ALIENS_IO_WATCHDOG_EN` undefined: no counter is built, `WDOG_RST` is tied to 0, and a write to offset 8 only updates `CTRL`.

## Structure
- Package `aliens_io_pkg` holds:
  - offset constants `IO_OFS_DSW3`, `IO_OFS_P1`, `IO_OFS_P2`, `IO_OFS_DSW2`, `IO_OFS_DSW1`, `IO_OFS_CTRL`, `IO_OFS_SND`
  - `CTRL` bit indices `CTRL_COIN1`, `CTRL_COIN2`, `CTRL_RMRD`
- One sub-module, `aliens_io_watchdog`:
  - inputs: `CLK12`, `RST`, `VBLANK`, `KICK`
  - output: `WDOG_RST`
  - carries both parameters
  - instantiated only under the macro.

## Test plan
1. Reset, then a read at offset 1 with `P1` = 0xA5: `DOUT` = 0xA5 and `DOE` = 1 one cycle after `rd_sel`. Offset 0 with `DSW3` = 0x3 gives 0xF3. Offset 7 gives 0xFF.
2. Write 0x23 to offset 8 with the strobe held 5 cycles: `CTRL` = 0x23, `COIN1` = 1, `COIN2` = 1, `RMRD` = 1. Exactly one commit. Mirror write to offset 0x18 behaves the same.
3. Write 0x42 to offset C, then 0x43 before any ack: `SND_LATCH` = 0x43 and `SND_IRQ` stays 1. An `SND_IACK` rise clears it one cycle later. A write coincident with an ack leaves `SND_IRQ` = 1.
4. With the macro defined, send 16 VBLANK edges with no kick: `WDOG_RST` = 1 for exactly 64 cycles. With a kick after 15 edges, no pulse. With the macro undefined, `WDOG_RST` stays 0.
5. Assert `RST` mid-pulse and with `SND_IRQ` = 1: next cycle `WDOG_RST` = 0, `SND_IRQ` = 0, `CTRL` = 0x00. A strobe still held after reset deasserts produces no write.
